// File: rtl/seg_frame_decoder.sv
// Six-digit seven-segment bus receiver: glitch filter, digit decode, blink detection, valid/ready frame output.
// Optional error counter output err_count is enabled by defining SEG_FRAME_ERRCNT_EN.
module seg_frame_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_TIMEOUT = 2500000,
    parameter int TO_W          = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg1,
    input  logic [6:0]  seg2,
    input  logic [6:0]  seg3,
    input  logic [6:0]  seg4,
    input  logic [6:0]  seg5,
    input  logic [6:0]  seg6,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [23:0] digits,
    output logic [5:0]  blink,
    output logic        overrun,
    output logic        decode_err
`ifdef SEG_FRAME_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(BLINK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(BLINK_TIMEOUT);
    localparam logic [3:0]      CODE_BLANK = 4'hF;
    localparam logic [3:0]      CODE_ERR   = 4'hE;

    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b1111110: decode_seg = 4'd0;
            7'b0110000: decode_seg = 4'd1;
            7'b1101101: decode_seg = 4'd2;
            7'b1111001: decode_seg = 4'd3;
            7'b0110011: decode_seg = 4'd4;
            7'b1011011: decode_seg = 4'd5;
            7'b1011111: decode_seg = 4'd6;
            7'b1110000: decode_seg = 4'd7;
            7'b1111111: decode_seg = 4'd8;
            7'b1111011: decode_seg = 4'd9;
            7'b0000000: decode_seg = CODE_BLANK;
            default:    decode_seg = CODE_ERR;
        endcase
    endfunction

    logic [41:0]     sample_q, prev_q, ref_q;
    logic [7:0]      stable_cnt_q;
    logic            accept;
    state_t          state_q, state_d;
    logic [5:0]      blink_q, blink_d;
    logic [3:0]      hold_q [6];
    logic [3:0]      hold_d [6];
    logic [TO_W-1:0] to_cnt_q [6];
    logic [TO_W-1:0] to_cnt_d [6];
    logic [3:0]      code [6];
    logic [23:0]     digits_d;
    logic            err_d;

    // prev_q is the sample the counter vouches for; ref_q is the last accepted frame.
    assign accept = (stable_cnt_q == STABLE_MAX) && (prev_q != ref_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q     <= '0;
            prev_q       <= '0;
            stable_cnt_q <= '0;
        end else begin
            sample_q <= {seg6, seg5, seg4, seg3, seg2, seg1};
            prev_q   <= sample_q;
            if (sample_q != prev_q)
                stable_cnt_q <= 8'd1;
            else if (stable_cnt_q != STABLE_MAX)
                stable_cnt_q <= stable_cnt_q + 8'd1;
        end
    end

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        blink_d  = blink_q;
        err_d    = 1'b0;
        digits_d = '0;
        for (int i = 0; i < 6; i++) begin
            code[i]     = decode_seg(prev_q[7*i +: 7]);
            hold_d[i]   = hold_q[i];
            to_cnt_d[i] = to_cnt_q[i];
            if (code[i] == CODE_ERR)
                err_d = 1'b1;
            if (accept) begin
                if (code[i] != CODE_BLANK) begin
                    hold_d[i]   = code[i];
                    to_cnt_d[i] = '0;
                end else if (ref_q[7*i +: 7] != 7'd0) begin
                    blink_d[i] = 1'b1;
                end
            end else if (blink_q[i] && ref_q[7*i +: 7] != 7'd0) begin
                if (to_cnt_q[i] == TO_LAST) begin
                    blink_d[i]  = 1'b0;
                    to_cnt_d[i] = TO_MAX;
                end else begin
                    to_cnt_d[i] = to_cnt_q[i] + 1'b1;
                end
            end
            // A blinking digit in its blank phase reports the code it last showed.
            digits_d[4*i +: 4] = (code[i] == CODE_BLANK && blink_d[i]) ? hold_d[i] : code[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PEND;
            PEND:    if (frame_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign frame_valid = (state_q == PEND);

    // NOTE: the per-digit hold/timeout arrays are reset too, since all state must read 0 in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ref_q      <= '0;
            blink_q    <= '0;
            digits     <= '0;
            blink      <= '0;
            overrun    <= 1'b0;
            decode_err <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hold_q[i]   <= '0;
                to_cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            for (int i = 0; i < 6; i++) begin
                hold_q[i]   <= hold_d[i];
                to_cnt_q[i] <= to_cnt_d[i];
            end
            if (accept) begin
                ref_q      <= prev_q;
                digits     <= digits_d;
                decode_err <= err_d;
            end
            // Blink output is frozen while a frame is pending, otherwise it follows the live flags.
            if (accept || state_d == IDLE)
                blink <= blink_d;
            if (accept && state_q == PEND && !frame_ready)
                overrun <= 1'b1;
        end
    end

`ifdef SEG_FRAME_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_count <= '0;
        else if (accept && err_d && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Scoreboard bench for seg_frame_decoder: stimulus queues expected frames, a negedge monitor checks handshakes.
// Runs with BLINK_TIMEOUT=20; the err_count check is active when SEG_FRAME_ERRCNT_EN is defined.
module tb_seg_frame_decoder;

    typedef struct packed {
        logic [23:0] digits;
        logic [5:0]  blink;
        logic        err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg1, seg2, seg3, seg4, seg5, seg6;
    logic        frame_ready;
    logic        frame_valid;
    logic [23:0] digits;
    logic [5:0]  blink;
    logic        overrun;
    logic        decode_err;
`ifdef SEG_FRAME_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    frame_t     exp_q[$];
    frame_t     mon_exp;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] pat [10];

    seg_frame_decoder #(
        .STABLE_CYCLES(4),
        .BLINK_TIMEOUT(20),
        .TO_W(22)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg1(seg1),
        .seg2(seg2),
        .seg3(seg3),
        .seg4(seg4),
        .seg5(seg5),
        .seg6(seg6),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .digits(digits),
        .blink(blink),
        .overrun(overrun),
        .decode_err(decode_err)
`ifdef SEG_FRAME_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = frame_valid;
        end
        check("wait_valid", 32'(seen), 32'd1);
    endtask

    task automatic expect_frame(input logic [23:0] d, input logic [5:0] b, input logic e);
        exp_q.push_back('{digits: d, blink: b, err: e});
    endtask

    // Monitor: every completed handshake must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame: got digits %h, expected no frame", digits);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame_digits", 32'(digits), 32'(mon_exp.digits));
                check("frame_blink", 32'(blink), 32'(mon_exp.blink));
                check("frame_decode_err", 32'(decode_err), 32'(mon_exp.err));
            end
        end
    end

    initial begin
        pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
        pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
        pat[8] = 7'b1111111; pat[9] = 7'b1111011;

        rst = 1'b0;
        frame_ready = 1'b1;
        {seg6, seg5, seg4, seg3, seg2, seg1} = '0;
        #2;
        check("reset_valid", 32'(frame_valid), 32'd0);
        check("reset_digits", 32'(digits), 32'd0);
        check("reset_blink", 32'(blink), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_decode_err", 32'(decode_err), 32'd0);
        #21 rst = 1'b1;
        step(8);
        check("blank_display_no_frame", 32'(frame_valid), 32'd0);

        // Digits 1..6: frame appears exactly 6 clocks after the change.
        expect_frame(24'h654321, 6'b0, 1'b0);
        seg1 = pat[1]; seg2 = pat[2]; seg3 = pat[3];
        seg4 = pat[4]; seg5 = pat[5]; seg6 = pat[6];
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_clk%0d", i), 32'(frame_valid), 32'(i == 6));
        end
        step(4);

        // Glitch filter: seg1 flips 8/0 every 2 clocks, only the settled 0 is accepted.
        expect_frame(24'h654320, 6'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            seg1 = (k % 2 == 0) ? pat[8] : pat[0];
            step(2);
        end
        step(12);

        // Blink on digit 3: 7, blank, 7, blank, then steady 7.
        expect_frame(24'h654720, 6'b000000, 1'b0);
        seg3 = pat[7];
        step(10);
        expect_frame(24'h654720, 6'b000100, 1'b0);
        seg3 = 7'd0;
        step(10);
        expect_frame(24'h654720, 6'b000100, 1'b0);
        seg3 = pat[7];
        step(10);
        expect_frame(24'h654720, 6'b000100, 1'b0);
        seg3 = 7'd0;
        step(10);
        expect_frame(24'h654720, 6'b000100, 1'b0);
        seg3 = pat[7];
        wait_valid(12);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 19) check("blink_before_timeout", 32'(blink[2]), 32'd1);
            if (k == 20) check("blink_after_timeout", 32'(blink[2]), 32'd0);
        end
        step(10);

        // Overrun: two frames while the consumer stalls; only the second is delivered.
        frame_ready = 1'b0;
        seg6 = pat[9];
        step(10);
        expect_frame(24'h854720, 6'b0, 1'b0);
        seg6 = pat[8];
        step(10);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_valid_held", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        step(1);
        check("ready_drops_valid", 32'(frame_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Unrecognised pattern on digit 5.
        expect_frame(24'h8E4720, 6'b0, 1'b1);
        seg5 = 7'b1000001;
        step(10);
`ifdef SEG_FRAME_ERRCNT_EN
        check("err_count", 32'(err_count), 32'd1);
`endif

        // Asynchronous reset while a frame is pending.
        frame_ready = 1'b0;
        seg5 = pat[5];
        wait_valid(12);
        check("overrun_before_reset", 32'(overrun), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_valid", 32'(frame_valid), 32'd0);
        check("async_reset_digits", 32'(digits), 32'd0);
        check("async_reset_blink", 32'(blink), 32'd0);
        check("async_reset_overrun", 32'(overrun), 32'd0);
        step(2);
        rst = 1'b1;
        step(3);

        check("all_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
